// File: rtl/ram_sp_clr_sync_read.sv
// Single-port RAM with a self-clearing sweep engine and a selectable read path:
// combinational (READ_LATENCY=0) or registered with a valid pulse (READ_LATENCY=1).
module ram_sp_clr_sync_read #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter int unsigned           READ_LATENCY = 1,
  parameter bit                    WRITE_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic                  clear,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = address;
    mem_wdata  = data_in;
    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = INIT_VALUE;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = READY;
      end
      READY: begin
        if (clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          mem_we = write_en;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: the array is deliberately not reset; the sweep initialises it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy = (state_q == CLEAR);

  if (READ_LATENCY == 0) begin : g_async_read
    assign data_out   = busy ? '0 : mem[address];
    assign data_valid = read_en & ~busy;
  end else begin : g_sync_read
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    // A clear in the same cycle wins over the read, so the read is only taken in READY without clear.
    always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (state_q == READY && !clear && read_en) begin
        valid_d = 1'b1;
        dout_d  = (write_en && WRITE_FIRST) ? data_in : mem[address];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
  end

endmodule
